// File: rtl/threshold_pkg.sv
// Shared types and helpers for the threshold filter configuration controller.
// Widths, FSM encoding, saturating add and unsigned clamp.
package threshold_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_e;

    function automatic int sum_width(input int dw, input int pw);
        return dw + pw;
    endfunction

    // Operands wider than w bits are not expected; result saturates at 2^w-1.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w
    );
        logic [63:0] s;
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        s = a + b;
        return (s > m) ? m : s;
    endfunction

    function automatic logic [15:0] clamp_u(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        hi = (32'sd1 <<< w) - 32'sd1;
        if (v < 32'sd0) return 16'd0;
        if (v > hi) return hi[15:0];
        return v[15:0];
    endfunction

endpackage

// File: rtl/threshold_ctrl_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, W cycles per result.
// done_o is high in the last iteration cycle; quotient_o is final after it.
module seq_divider #(
    parameter int W  = 30,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [W-1:0]  dividend_i,
    input  logic [W-1:0]  divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [QW-1:0] quotient_o
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [W:0]    trial;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        // partial remainder stays below divisor, so W+1 bits hold the sign
        trial  = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
        if (start_i && !busy_q) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial[W]) begin
                rem_d = {rem_q[W-2:0], quo_q[W-1]};
                quo_d = {quo_q[W-2:0], 1'b0};
            end else begin
                rem_d = trial[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CW'(1));
    assign quotient_o = quo_q[QW-1:0];

endmodule

// File: rtl/threshold_ctrl.sv
// Frame-synchronous threshold/max configuration for the binary threshold filter.
// Measures each frame's mean on a passive stream tap and commits between frames.
module threshold_ctrl
    import threshold_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PIX_CNT_W  = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    input  logic [DATA_WIDTH-1:0] mon_tdata,
    input  logic                  mon_tlast,
    input  logic                  mon_tuser,
    input  logic                  cfg_auto,
    input  logic [DATA_WIDTH-1:0] cfg_manual_thr,
    input  logic [DATA_WIDTH:0]   cfg_offset,
    input  logic [DATA_WIDTH-1:0] cfg_max_value,
    input  logic [15:0]           cfg_height,
    output logic [DATA_WIDTH-1:0] threshold_value,
    output logic [DATA_WIDTH-1:0] max_value,
    output logic [DATA_WIDTH-1:0] mean_value,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  overrun
);
    localparam int SUM_W = sum_width(DATA_WIDTH, PIX_CNT_W);

    state_e                state_q, state_d;
    logic                  active_q, active_d;
    logic [SUM_W-1:0]      sum_q, sum_d, sum_cur;
    logic [PIX_CNT_W-1:0]  cnt_q, cnt_d, cnt_cur;
    logic [15:0]           line_q, line_d, line_cur, hmax;
    logic [16:0]           line_nxt;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] thr_q, thr_d;
    logic [DATA_WIDTH-1:0] maxv_q, maxv_d;
    logic [DATA_WIDTH-1:0] mean_q, mean_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0] man_prev_q, max_prev_q;
    logic                  auto_prev_q;

    logic beat, sof, acc, counted, eof, commit, man_set;
    logic div_start, div_busy, div_done;
    logic [DATA_WIDTH-1:0]   div_quo, next_thr;
    logic signed [DATA_WIDTH+1:0] thr_sum;
    logic [31:0]             thr_ext;

    assign beat     = mon_tvalid && mon_tready;
    assign sof      = beat && mon_tuser;
    assign acc      = beat && !mon_tuser && active_q;
    assign counted  = sof || acc;
    assign hmax     = (cfg_height == 16'd0) ? 16'd1 : cfg_height;
    assign line_cur = sof ? 16'd0 : line_q;
    assign line_nxt = {1'b0, line_cur} + 17'd1;
    assign eof      = counted && mon_tlast && (line_nxt == {1'b0, hmax});

    assign sum_cur = sof ? SUM_W'(mon_tdata)
                         : SUM_W'(sat_add(64'(sum_q), 64'(mon_tdata), SUM_W));
    assign cnt_cur = sof ? PIX_CNT_W'(1)
                         : PIX_CNT_W'(sat_add(64'(cnt_q), 64'd1, PIX_CNT_W));

    assign thr_sum  = $signed({2'b00, mean_q})
                    + $signed({cfg_offset[DATA_WIDTH], cfg_offset});
    assign thr_ext  = {{(30 - DATA_WIDTH){thr_sum[DATA_WIDTH+1]}}, thr_sum};
    assign next_thr = DATA_WIDTH'(clamp_u(thr_ext, DATA_WIDTH));

    // any manual-side edit, including leaving or entering manual mode
    assign man_set = ((cfg_manual_thr != man_prev_q)
                   || (cfg_max_value != max_prev_q)
                   || (cfg_auto != auto_prev_q))
                   && (!cfg_auto || !auto_prev_q);
    assign commit  = pend_q && !active_q && !sof;

    seq_divider #(
        .W (SUM_W),
        .QW(DATA_WIDTH)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (div_start),
        .dividend_i(sum_cur),
        .divisor_i (SUM_W'(cnt_cur)),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quotient_o(div_quo)
    );

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        pend_d    = pend_q;
        thr_d     = thr_q;
        maxv_d    = maxv_q;
        mean_d    = mean_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ovr_d     = 1'b0;
        div_start = 1'b0;

        if (sof) begin
            err_d    = active_q;
            active_d = 1'b1;
            sum_d    = sum_cur;
            cnt_d    = cnt_cur;
            line_d   = 16'd0;
        end else if (acc) begin
            sum_d = sum_cur;
            cnt_d = cnt_cur;
        end
        if (counted && mon_tlast) begin
            if (eof) active_d = 1'b0;
            else     line_d   = line_nxt[15:0];
        end

        unique case (state_q)
            IDLE: begin
                if (eof) begin
                    div_start = 1'b1;
                    state_d   = DIVIDE;
                end
            end
            DIVIDE: begin
                ovr_d = eof;
                if (div_done) state_d = DONE;
            end
            DONE: begin
                ovr_d   = eof;
                mean_d  = div_quo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            thr_d  = cfg_auto ? next_thr : cfg_manual_thr;
            maxv_d = cfg_max_value;
            pend_d = 1'b0;
        end
        if (state_q == DONE || man_set) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            line_q      <= '0;
            pend_q      <= 1'b0;
            thr_q       <= '0;
            maxv_q      <= '0;
            mean_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            man_prev_q  <= '0;
            max_prev_q  <= '0;
            auto_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            pend_q      <= pend_d;
            thr_q       <= thr_d;
            maxv_q      <= maxv_d;
            mean_q      <= mean_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            man_prev_q  <= cfg_manual_thr;
            max_prev_q  <= cfg_max_value;
            auto_prev_q <= cfg_auto;
        end
    end

    assign threshold_value = thr_q;
    assign max_value       = maxv_q;
    assign mean_value      = mean_q;
    assign busy            = div_busy;
    assign frame_done      = done_q;
    assign frame_err       = err_q;
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_threshold_ctrl.sv
// Randomized bench for threshold_ctrl against a frame-level reference model.
// Model works on pixel queues, integer mean and a cycle schedule for results.
module tb_threshold_ctrl;
    localparam int DW = 8;
    localparam int PW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mon_tvalid, mon_tready, mon_tlast, mon_tuser;
    logic [DW-1:0] mon_tdata;
    logic          cfg_auto;
    logic [DW-1:0] cfg_manual_thr, cfg_max_value;
    logic [DW:0]   cfg_offset;
    logic [15:0]   cfg_height;
    logic [DW-1:0] threshold_value, max_value, mean_value;
    logic          busy, frame_done, frame_err, overrun;

    always #5 clk = ~clk;

    threshold_ctrl #(
        .DATA_WIDTH(DW),
        .PIX_CNT_W (PW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mon_tvalid     (mon_tvalid),
        .mon_tready     (mon_tready),
        .mon_tdata      (mon_tdata),
        .mon_tlast      (mon_tlast),
        .mon_tuser      (mon_tuser),
        .cfg_auto       (cfg_auto),
        .cfg_manual_thr (cfg_manual_thr),
        .cfg_offset     (cfg_offset),
        .cfg_max_value  (cfg_max_value),
        .cfg_height     (cfg_height),
        .threshold_value(threshold_value),
        .max_value      (max_value),
        .mean_value     (mean_value),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .overrun        (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit stall = 1'b1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference model state
    bit m_active;
    int m_line;
    int m_pix[$];
    int m_last_eof, m_done_at, m_result;
    bit m_pend;
    int m_mean, m_thr, m_max;
    bit e_done, e_err, e_ovr;
    int p_man, p_max;
    bit p_auto;

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic model_reset();
        m_active = 0; m_line = 0; m_pix.delete();
        m_last_eof = -1000; m_done_at = -1; m_result = 0;
        m_pend = 0; m_mean = 0; m_thr = 0; m_max = 0;
        e_done = 0; e_err = 0; e_ovr = 0;
        p_man = 0; p_max = 0; p_auto = 0;
    endtask

    task automatic model_step();
        bit beat, sof, cnt, commit;
        int h, sum;
        e_done = 0; e_err = 0; e_ovr = 0;
        beat = mon_tvalid && mon_tready;
        sof  = beat && mon_tuser;
        cnt  = sof || (beat && m_active);
        h    = (cfg_height == 0) ? 1 : int'(cfg_height);
        commit = m_pend && !m_active && !sof;
        if (commit) begin
            m_thr  = cfg_auto ? clamp8(m_mean + int'($signed(cfg_offset))) : int'(cfg_manual_thr);
            m_max  = cfg_max_value;
            m_pend = 0;
        end
        if (cyc == m_done_at) begin
            m_mean = m_result; e_done = 1; m_pend = 1;
        end
        if ((int'(cfg_manual_thr) != p_man || int'(cfg_max_value) != p_max
             || cfg_auto != p_auto) && (!cfg_auto || !p_auto))
            m_pend = 1;
        p_man = cfg_manual_thr; p_max = cfg_max_value; p_auto = cfg_auto;
        if (sof) begin
            e_err = m_active;
            m_pix.delete(); m_active = 1; m_line = 0;
        end
        if (cnt) begin
            m_pix.push_back(int'(mon_tdata));
            if (mon_tlast) begin
                m_line++;
                if (m_line == h) begin
                    m_active = 0;
                    if (cyc - m_last_eof <= 31) e_ovr = 1;
                    else begin
                        sum = 0;
                        foreach (m_pix[i]) sum += m_pix[i];
                        m_result   = (sum / m_pix.size()) % 256;
                        m_done_at  = cyc + 31;
                        m_last_eof = cyc;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        int eb;
        eb = (cyc >= m_last_eof && cyc <= m_last_eof + 29) ? 1 : 0;
        chk("thr", threshold_value, m_thr);
        chk("max", max_value, m_max);
        chk("mean", mean_value, m_mean);
        chk("busy", busy, eb);
        chk("done", frame_done, e_done);
        chk("err", frame_err, e_err);
        chk("ovr", overrun, e_ovr);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare();
    endtask

    task automatic send(input int d, input bit l, input bit u);
        bit hs;
        int tries = 0;
        do begin
            if (stall && tries < 8) begin
                mon_tvalid = ($urandom_range(0, 3) != 0);
                mon_tready = ($urandom_range(0, 3) != 0);
            end else begin
                mon_tvalid = 1'b1;
                mon_tready = 1'b1;
            end
            hs = mon_tvalid && mon_tready;
            if (hs) begin
                mon_tdata = DW'(d); mon_tlast = l; mon_tuser = u;
            end else begin
                mon_tdata = DW'($urandom); mon_tlast = 1'($urandom); mon_tuser = 1'($urandom);
            end
            tries++;
            tick();
        end while (!hs);
        mon_tvalid = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
    endtask

    // kind: 0 constant, 1 ramp from base, 2 random
    task automatic frame(input int w, input int h, input int kind, input int base,
                         input int stop, input int chg_at);
        int n = 0;
        int hh = (h < 1) ? 1 : h;
        for (int y = 0; y < hh; y++) begin
            for (int x = 0; x < w; x++) begin
                int d;
                if (n == stop) return;
                if (n == chg_at) begin
                    cfg_auto = 1'b0; cfg_manual_thr = 8'd77;
                end
                d = (kind == 0) ? base : (kind == 1) ? base + n : int'($urandom_range(0, 255));
                send(d, x == w - 1, n == 0);
                n++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            mon_tvalid = 1'($urandom); mon_tready = 1'($urandom);
            mon_tuser  = 1'b0; mon_tlast = 1'($urandom); mon_tdata = DW'($urandom);
            tick();
        end
        mon_tvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        mon_tvalid = 0; mon_tready = 0; mon_tdata = 0; mon_tlast = 0; mon_tuser = 0;
        cfg_auto = 1'b1; cfg_manual_thr = 0; cfg_offset = 9'd5;
        cfg_max_value = 8'd200; cfg_height = 16'd4;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        stall = 1'b0;
        frame(4, 4, 0, 100, -1, -1);
        idle(40);
        chk("tp_mean100", mean_value, 100);
        chk("tp_thr105", threshold_value, 105);
        stall = 1'b1;

        cfg_height = 16'd1; cfg_offset = 9'd0;
        frame(16, 1, 1, 0, -1, -1);
        idle(40);
        chk("tp_ramp_mean7", mean_value, 7);

        cfg_height = 16'd0; cfg_offset = 9'd20;
        frame(3, 0, 0, 250, -1, -1);
        idle(40);
        chk("tp_clamp_hi", threshold_value, 255);

        cfg_height = 16'd1; cfg_offset = 9'h1E2;
        frame(4, 1, 0, 10, -1, -1);
        idle(40);
        chk("tp_clamp_lo", threshold_value, 0);

        cfg_height = 16'd4;
        frame(4, 4, 2, 0, -1, 8);
        chk("tp_man_hold", threshold_value, 0);
        idle(1);
        chk("tp_man_77", threshold_value, 77);
        idle(40);
        cfg_auto = 1'b1; cfg_offset = 9'd3;
        idle(5);

        frame(4, 4, 2, 0, -1, -1);
        idle(4);
        frame(4, 4, 2, 0, -1, -1);
        idle(40);

        frame(4, 4, 2, 0, 6, -1);
        frame(4, 4, 2, 0, -1, -1);
        idle(40);

        stall = 1'b0; cfg_height = 16'd1;
        frame(2, 1, 0, 40, -1, -1);
        frame(2, 1, 0, 200, -1, -1);
        idle(40);
        chk("tp_ovr_mean", mean_value, 40);

        cfg_height = 16'd4;
        frame(4, 4, 0, 60, -1, -1);
        idle(10);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_thr", threshold_value, 0);
        chk("rst_mean", mean_value, 0);
        chk("rst_busy", busy, 0);
        compare();
        tick();
        tick();
        rst_n = 1'b1;
        stall = 1'b1;
        frame(4, 4, 0, 60, -1, -1);
        idle(40);
        chk("rst_recover", mean_value, 60);

        for (int k = 0; k < 14; k++) begin
            int w, h;
            w = $urandom_range(1, 5);
            h = $urandom_range(0, 4);
            cfg_height     = 16'(h);
            cfg_auto       = ($urandom_range(0, 3) != 0);
            cfg_manual_thr = DW'($urandom);
            cfg_max_value  = DW'($urandom);
            cfg_offset     = 9'($urandom);
            stall          = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 5) == 0)
                frame(w, h, 2, 0, $urandom_range(1, 4), -1);
            frame(w, h, $urandom_range(0, 2), $urandom_range(0, 240), -1, -1);
            idle($urandom_range(0, 45));
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/threshold_ctrl.md
# threshold_ctrl

Frame-synchronous configuration controller for the binary threshold filter. It passively taps the filter's input AXI4-Stream, measures the mean pixel value of each frame, and drives the filter's `threshold_value`/`max_value` configuration ports. Updates are applied only between frames, so the filter never switches threshold mid-frame. Mode is either automatic (next threshold = measured mean + offset) or manual (software value passed through).

## Interface
- DATA_WIDTH, 8, pixel width; must match the filter.
- PIX_CNT_W, 22, pixel-counter width; maximum frame size is 2^PIX_CNT_W−1 pixels.
- SUM_W (localparam), DATA_WIDTH+PIX_CNT_W, accumulator, divider and iteration-count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mon_tvalid / mon_tready  in  1 / 1  tap of the filter's input handshake; a beat is counted only when both are high.
- mon_tdata  in  DATA_WIDTH  tapped pixel
- mon_tlast  in  1  end of line
- mon_tuser  in  1  start of frame
- cfg_auto  in  1  1 = automatic, 0 = manual
- cfg_manual_thr  in  DATA_WIDTH  threshold used in manual mode
- cfg_offset  in  DATA_WIDTH+1  signed offset added to the mean
- cfg_max_value  in  DATA_WIDTH  output high value
- cfg_height  in  16  lines per frame; 0 is treated as 1
- threshold_value  out  DATA_WIDTH  to the filter
- max_value  out  DATA_WIDTH  to the filter
- mean_value  out  DATA_WIDTH  mean of the last completed frame
- busy  out  1  divider running
- frame_done  out  1  one-cycle pulse when mean_value updates
- frame_err  out  1  one-cycle pulse on a truncated frame
- overrun  out  1  one-cycle pulse when a frame result is dropped

## Operation
- **Reset values.** All outputs are 0. The accumulator, counters and pending flag are cleared. The FSM is in IDLE.
- **Start of frame.** A beat with tuser=1 sets frame_active. It loads sum = tdata, count = 1, line = 0.
  - If frame_active was already set, the partial frame is discarded and frame_err pulses.
- **Accumulation.** A beat with frame_active=1 and tuser=0 adds tdata to sum and increments count.
  - Beats arriving while frame_active=0 without tuser are ignored.
  - Sum and count saturate at their maximum; they do not wrap.
- **Line counting.** Each counted beat with tlast increments line.
- **End of frame.** The frame ends on the tlast beat where line+1 == max(cfg_height,1). That beat is included in the frame, and frame_active clears.
- **FSM.**
  - IDLE: on end of frame, snapshot sum/count into the divider and go to DIVIDE.
  - DIVIDE: restoring division, one quotient bit per cycle, SUM_W cycles. busy=1.
  - DONE: quotient, truncated to DATA_WIDTH, is written to mean_value. frame_done pulses. pending is set. Return to IDLE.
- **Overrun.** End of frame while in DIVIDE pulses overrun. The new snapshot is dropped; the running division continues.
- **Auto threshold.** next_thr = clamp(mean + cfg_offset, 0, 2^DATA_WIDTH−1), computed signed at DATA_WIDTH+2 bits.
- **Commit.** When pending=1 and frame_active=0:
  - threshold_value ← next_thr if cfg_auto=1, otherwise cfg_manual_thr.
  - max_value ← cfg_max_value.
  - pending clears.
  - If a new start of frame arrives first, the commit is deferred until that frame ends. A start-of-frame beat and a commit in the same cycle: the commit is suppressed.
- **Manual mode.** Any change to cfg_manual_thr, cfg_max_value or cfg_auto while in manual mode also sets pending, so manual values commit at the next inactive cycle without waiting for a division.
- **Reset mid-operation.** Any in-flight division, pending value and partial frame are lost. Outputs return to 0.

## Timing
- Final tlast beat of a frame at cycle T:
  - DIVIDE occupies T+1 … T+SUM_W.
  - DONE at T+SUM_W+1: mean_value and frame_done valid.
  - threshold_value updates at T+SUM_W+2 if still between frames.
- Defaults (SUM_W=30): threshold updates 32 cycles after the frame ends.
- The controller never drives the handshake; it adds no backpressure and no latency to the filter.
- All outputs are registered.

## Structure
- Package `threshold_pkg`:
  - SUM_W width function.
  - FSM enum {IDLE, DIVIDE, DONE}.
  - Saturating-add and clamp functions.
- Sub-module `seq_divider`: start/busy/done handshake, parameterised width, unsigned restoring division.

## Test plan
- 4×4 frame, all pixels 100, auto mode, offset +5 → mean_value=100, frame_done at T+31, threshold_value=105 at T+32.
- Ramp frame 0..15 (1×16, height 1), offset 0 → mean 7 (truncated). Mean 250 with offset +20 → 255. Mean 10 with offset −30 → 0.
- Manual mode: cfg_manual_thr=77 written mid-frame → threshold_value stays at its old value until the frame's last tlast, then 77 on the next cycle.
- Next start of frame arrives 5 cycles after the end of frame (division not done) → threshold constant throughout the frame, updated the cycle after that frame ends.
- Start of frame after 6 beats of a 4×4 frame → frame_err pulses, and the new frame's mean excludes the first 6 pixels. Back-to-back 1×2 frames → overrun pulses, and only the first frame's mean is reported.
- rst_n asserted mid-DIVIDE → all outputs 0 immediately. The next full frame produces the correct result.
